// File: rtl/instr_fetch.sv
// Instruction fetch unit: a four-state request/response fetcher.
// It holds one instruction until the downstream stage retires it, then
// fetches either the sequential PC or the redirect target.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | one-cycle settle after reset release, no memory activity
// REQ   | imem_req high, imem_addr = pc, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid to capture data
// HOLD  | instruction held and valid, retires when stall is low
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_BASE = RESET_PC & 32'hFFFF_FFFC;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        run_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic        capture;
  logic        retire;

  assign capture = (state_q == WAIT) && imem_rvalid;
  assign retire  = (state_q == HOLD) && !stall;

  // Reset-release synchroniser: IDLE only advances once this has seen a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Next-state decode; responses outside WAIT never reach the capture path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_q)      state_d = REQ;
      REQ:     if (imem_ready) state_d = WAIT;
      WAIT:    if (imem_rvalid) state_d = HOLD;
      HOLD:    if (!stall)     state_d = REQ;
      default:                 state_d = IDLE;
    endcase
  end

  // Next PC is chosen only at retire; the target is word-aligned.
  always_comb begin
    pc_d = pc_q;
    if (retire) begin
      if (pc_src) begin
        pc_d = pc_target & 32'hFFFF_FFFC;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_BASE;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        instr_q <= imem_rdata;
      end
    end
  end

  // Outputs are Moore-style; instr falls back to NOP whenever nothing is held.
  always_comb begin
    imem_req    = (state_q == REQ);
    imem_addr   = pc_q;
    instr_valid = (state_q == HOLD);
    instr       = instr_valid ? instr_q : NOP;
    op          = instr[6:0];
    funct3      = instr[14:12];
    funct7      = instr[31:25];
    pc          = pc_q;
    pc_plus4    = pc_q + 32'd4;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances share stimulus, one with the
// default reset PC and one starting at the top of the address space.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;

  logic        imem_req,  imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic        instr_valid, instr_valid_w;
  logic [31:0] instr, instr_w;
  logic [6:0]  op, op_w;
  logic [2:0]  funct3, funct3_w;
  logic [6:0]  funct7, funct7_w;
  logic [31:0] pc, pc_w;
  logic [31:0] pc_plus4, pc_plus4_w;

  int total = 0;
  int bad   = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .instr_valid(instr_valid), .instr(instr),
    .op(op), .funct3(funct3), .funct7(funct7),
    .pc(pc), .pc_plus4(pc_plus4)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .instr_valid(instr_valid_w), .instr(instr_w),
    .op(op_w), .funct3(funct3_w), .funct7(funct7_w),
    .pc(pc_w), .pc_plus4(pc_plus4_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'h0;
    tick();
    tick();

    // reset values
    chk("rst_req",    {31'b0, imem_req},    32'd0);
    chk("rst_valid",  {31'b0, instr_valid}, 32'd0);
    chk("rst_instr",  instr,                32'h0000_0013);
    chk("rst_op",     {25'b0, op},          32'h13);
    chk("rst_f3",     {29'b0, funct3},      32'h0);
    chk("rst_f7",     {25'b0, funct7},      32'h0);
    chk("rst_pc",     pc,                   32'h0);
    chk("rst_pc_w",   pc_w,                 32'hFFFF_FFFC);

    // release: first edge stays in IDLE, second edge raises imem_req
    rst_n = 1'b1;
    tick();
    chk("idle_req",   {31'b0, imem_req},    32'd0);
    tick();
    chk("req_on",     {31'b0, imem_req},    32'd1);
    chk("req_addr",   imem_addr,            32'h0);

    // zero-wait memory; a response in the acceptance cycle must be ignored
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk("acc_resp_ign", {31'b0, instr_valid}, 32'd0);
    chk("wait_req",     {31'b0, imem_req},    32'd0);
    imem_ready  = 1'b0;
    imem_rdata  = 32'h0000_0093;
    tick();
    chk("zw_valid",   {31'b0, instr_valid}, 32'd1);
    chk("zw_instr",   instr,                32'h0000_0093);
    chk("zw_op",      {25'b0, op},          32'h13);
    chk("zw_pc",      pc,                   32'h0);
    chk("zw_pc4",     pc_plus4,             32'h4);
    chk("wrap_pc4",   pc_plus4_w,           32'h0);

    // stall 5 cycles with redirect inputs and stray responses that must be ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    stall       = 1'b1;
    pc_src      = 1'b1;
    pc_target   = 32'h0000_0500;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr,                32'h0000_0093);
      chk("stall_req",   {31'b0, imem_req},    32'd0);
      chk("stall_pc",    pc,                   32'h0);
    end

    // sequential retire
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    pc_src      = 1'b0;
    tick();
    chk("seq_req",    {31'b0, imem_req},    32'd1);
    chk("seq_addr",   imem_addr,            32'h4);
    chk("seq_valid",  {31'b0, instr_valid}, 32'd0);
    chk("seq_nop",    instr,                32'h0000_0013);
    chk("seq_op_nop", {25'b0, op},          32'h13);
    chk("wrap_addr",  imem_addr_w,          32'h0);

    // ready held off 3 cycles; stray rvalid in REQ is ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_req",  {31'b0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr,         32'h4);
    end
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    tick();
    imem_ready  = 1'b0;
    chk("dly_acc_req", {31'b0, imem_req}, 32'd0);
    chk("dly_acc_addr", imem_addr,        32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_wait_valid", {31'b0, instr_valid}, 32'd0);
      chk("dly_wait_addr",  imem_addr,            32'h4);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h40B5_0533;
    stall       = 1'b1;
    tick();
    chk("dly_valid", {31'b0, instr_valid}, 32'd1);
    chk("dly_instr", instr,                32'h40B5_0533);
    chk("dly_op",    {25'b0, op},          32'h33);
    chk("dly_f3",    {29'b0, funct3},      32'h0);
    chk("dly_f7",    {25'b0, funct7},      32'h20);
    chk("dly_pc",    pc,                   32'h4);
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("one_capture", instr, 32'h40B5_0533);

    // redirect retire; target low bits dropped
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    pc_src      = 1'b1;
    pc_target   = 32'h0000_0103;
    tick();
    pc_src      = 1'b0;
    pc_target   = 32'h0;
    chk("br_req",  {31'b0, imem_req}, 32'd1);
    chk("br_addr", imem_addr,         32'h0000_0100);

    // reset pulsed during WAIT, then a late response
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("pre_rst_wait", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_pc",    pc,                   32'h0);
    chk("arst_instr", instr,                32'h0000_0013);
    #1;
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0093;
    tick();
    chk("late_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_req",   {31'b0, imem_req},    32'd0);
    imem_rvalid = 1'b0;
    tick();
    chk("restart_req",   {31'b0, imem_req},    32'd1);
    chk("restart_addr",  imem_addr,            32'h0);
    chk("restart_valid", {31'b0, instr_valid}, 32'd0);

    // zero-wait fetch of a load to check funct3 decode
    imem_ready = 1'b1;
    tick();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0002_A283;
    stall       = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    chk("ld_valid", {31'b0, instr_valid}, 32'd1);
    chk("ld_op",    {25'b0, op},          32'h03);
    chk("ld_f3",    {29'b0, funct3},      32'h2);
    chk("ld_pc4",   pc_plus4,             32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset (bits [1:0] SHALL be treated as 0).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; SHALL equal pc.
REQ-006 imem_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  read data valid this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 stall  input  1  downstream hold; the held instruction SHALL NOT retire while high.
REQ-010 pc_src  input  1  redirect select, sampled at retire (1 = take pc_target).
REQ-011 pc_target  input  32  branch/jump target.
REQ-012 instr_valid  output  1  instr and the field outputs hold a fetched instruction.
REQ-013 instr  output  32  held instruction word, or NOP 32'h0000_0013 when instr_valid=0.
REQ-014 op / funct3 / funct7  output  7 / 3 / 7  instr[6:0], instr[14:12], instr[31:25], feeding the control unit.
REQ-015 pc / pc_plus4  output  32 / 32  address of the held instruction, and pc+4.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT and HOLD.
REQ-017 IDLE SHALL last exactly one cycle, then go to REQ.
REQ-018 In REQ, imem_req SHALL be 1, with imem_addr stable until the acceptance cycle.
REQ-019 REQ SHALL go to WAIT on imem_ready=1; the request SHALL NOT be withdrawn before that.
REQ-020 In WAIT, on imem_rvalid=1, imem_rdata SHALL be captured into instr and the FSM SHALL go to HOLD.
REQ-021 imem_rvalid in any state other than WAIT SHALL be ignored.
REQ-022 A response in the same cycle as acceptance SHALL be ignored; the earliest valid response is one cycle after acceptance.
REQ-023 instr_valid SHALL be 1 exactly in HOLD.
REQ-024 Retire SHALL occur when the FSM is in HOLD and stall=0.
REQ-025 At retire, next pc SHALL be pc_src ? {pc_target[31:2],2'b00} : pc+4, and the FSM SHALL go to REQ.
REQ-026 pc_src and pc_target SHALL be ignored outside the retire cycle.
REQ-027 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-028 stall=1 in HOLD SHALL keep instr, pc and the field outputs unchanged.
REQ-029 With a zero-wait memory (ready in REQ, rvalid next cycle), instr_valid SHALL rise 2 cycles after entering REQ.
REQ-030 Minimum throughput SHALL be 1 instruction per 3 cycles.
REQ-031 When instr_valid=0, the field outputs SHALL decode the NOP: op=7'b0010011, funct3=0, funct7=0.

Reset
REQ-032 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=32'h0000_0013.
REQ-033 Reset asserted mid-fetch (REQ or WAIT) SHALL abandon the transaction; a late imem_rvalid after reset SHALL be ignored.
REQ-034 Reset release SHALL be synchronised to clk; the first imem_req SHALL assert on the second rising edge after deassertion.

Verification
REQ-035 Reset release, zero-wait memory returning 32'h0000_0093 -> imem_addr=0; instr_valid rises with op=7'h13, pc=0, pc_plus4=4.
REQ-036 stall=1 for 5 cycles in HOLD -> outputs frozen, no imem_req; stall=0 -> next imem_addr=4.
REQ-037 Retire with pc_src=1, pc_target=32'h0000_0103 -> next imem_addr=32'h0000_0100.
REQ-038 RESET_PC=32'hFFFF_FFFC, sequential retire -> next imem_addr=32'h0000_0000.
REQ-039 imem_ready delayed 3 cycles and rvalid delayed 4 cycles -> imem_addr stable throughout; exactly one capture.
REQ-040 rst_n pulsed low in WAIT, then rvalid asserted -> instr_valid stays 0; fetch restarts at RESET_PC.
